// File: rtl/max_stream_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : max_stream_argmax
//  Description : Streaming per-frame extreme-value finder. Samples arrive on
//                a valid/ready handshake; for each frame (terminated by
//                in_last) the block reports the maximum or minimum sample
//                and the 0-based beat index of its first occurrence. The
//                compare is signed or unsigned according to SIGNED.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   : sample width in bits (>= 2)
//    IDX_W   : beat index / counter width (>= 1)
//    SIGNED  : 1 = two's-complement compare, 0 = unsigned compare
//  Ports
//    clk       in   rising-edge clock
//    rst       in   synchronous active-high reset
//    in_valid  in   sample present
//    in_ready  out  block can accept a sample (registered state only)
//    in_data   in   sample value
//    in_last   in   final beat of the frame
//    mode_min  in   0 = maximum, 1 = minimum (taken on first beat only)
//    out_valid out  frame result available
//    out_ready in   consumer accepts the result
//    out_val   out  extreme value of the frame
//    out_idx   out  beat index of first occurrence of out_val
//    out_ovf   out  frame held more than 2^IDX_W beats
// ============================================================================
module max_stream_argmax #(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode_min,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] c_cnt_max = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] c_cnt_one = IDX_W'(1);

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    // Set once a beat has been taken at the saturated index, i.e. the
    // previous beat index was already all-ones.
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_val_q, out_val_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_ovf_q, out_ovf_d;

    logic w_gt;
    logic w_lt;
    logic w_win;
    logic w_accept;
    logic w_cnt_sat;

    generate
        if (SIGNED) begin : g_signed
            assign w_gt = $signed(in_data) > $signed(best_q);
            assign w_lt = $signed(in_data) < $signed(best_q);
        end else begin : g_unsigned
            assign w_gt = in_data > best_q;
            assign w_lt = in_data < best_q;
        end
    endgenerate

    // Strict compare: ties never win, so the earliest index is kept.
    assign w_win     = mode_q ? w_lt : w_gt;
    assign w_accept  = in_valid && (state_q == ACCUM);
    assign w_cnt_sat = (cnt_q == c_cnt_max);

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        mode_d     = mode_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        out_val_d  = out_val_q;
        out_idx_d  = out_idx_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            ACCUM: begin
                if (w_accept) begin
                    if (first_q) begin
                        best_d     = in_data;
                        best_idx_d = '0;
                        cnt_d      = c_cnt_one;
                        mode_d     = mode_min;
                        ovf_d      = 1'b0;
                        sat_d      = 1'b0;
                        first_d    = 1'b0;
                    end else begin
                        if (w_win) begin
                            best_d     = in_data;
                            best_idx_d = cnt_q;
                        end
                        if (w_cnt_sat) begin
                            if (sat_q) begin
                                ovf_d = 1'b1;
                            end
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end

                    // Result includes the last beat itself.
                    if (in_last) begin
                        out_val_d = best_d;
                        out_idx_d = best_idx_d;
                        out_ovf_d = ovf_d;
                        state_d   = HOLD;
                        first_d   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            first_q    <= 1'b1;
            mode_q     <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            out_val_q  <= '0;
            out_idx_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            mode_q     <= mode_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            out_val_q  <= out_val_d;
            out_idx_q  <= out_idx_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_val   = out_val_q;
    assign out_idx   = out_idx_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_max_stream_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_stream_argmax
//  Description : Directed self-checking bench. Three instances share one
//                input stream: u0 unsigned IDX_W=8, u1 signed IDX_W=8,
//                u2 unsigned IDX_W=2. Handshake timing is identical across
//                instances, so each frame checks all relevant results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_stream_argmax;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       mode_min;
    logic       out_ready;

    logic       rdy0, rdy1, rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] val0, val1, val2;
    logic [7:0] idx0, idx1;
    logic [1:0] idx2;
    logic       ovf0, ovf1, ovf2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    max_stream_argmax #(.WIDTH(8), .IDX_W(8), .SIGNED(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .mode_min(mode_min),
        .out_valid(ov0), .out_ready(out_ready), .out_val(val0),
        .out_idx(idx0), .out_ovf(ovf0));

    max_stream_argmax #(.WIDTH(8), .IDX_W(8), .SIGNED(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .mode_min(mode_min),
        .out_valid(ov1), .out_ready(out_ready), .out_val(val1),
        .out_idx(idx1), .out_ovf(ovf1));

    max_stream_argmax #(.WIDTH(8), .IDX_W(2), .SIGNED(1'b0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_last(in_last), .mode_min(mode_min),
        .out_valid(ov2), .out_ready(out_ready), .out_val(val2),
        .out_idx(idx2), .out_ovf(ovf2));

    task automatic chk_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, waiting (bounded) for in_ready; returns #1 after
    // the accepting edge with in_valid dropped.
    task automatic send_beat(input logic [7:0] d, input logic last,
                             input logic mm);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode_min = mm;
        while (!rdy0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk_val("ready_timeout", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
        in_last  = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_val({tag, "_rdy"},  32'({rdy0, rdy1, rdy2}), 32'b111);
        chk_val({tag, "_ov"},   32'({ov0, ov1, ov2}),    32'b000);
        chk_val({tag, "_val"},  32'({val0, val1, val2}), 32'h0);
        chk_val({tag, "_idx"},  32'({idx0, idx1, idx2}), 32'h0);
        chk_val({tag, "_ovf"},  32'({ovf0, ovf1, ovf2}), 32'b000);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        mode_min  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;

        // Frame A: unsigned max 3,9,9,2 -> 9 @ 1 (tie keeps earlier index)
        send_beat(8'd3, 1'b0, 1'b0);
        send_beat(8'd9, 1'b0, 1'b0);
        send_beat(8'd9, 1'b0, 1'b0);
        send_beat(8'd2, 1'b1, 1'b0);
        chk_val("a_valid_lat", 32'(ov0), 32'd1);
        chk_val("a_ready_low", 32'(rdy0), 32'd0);
        chk_val("a_val", 32'(val0), 32'd9);
        chk_val("a_idx", 32'(idx0), 32'd1);
        chk_val("a_ovf", 32'(ovf0), 32'd0);
        chk_val("a_s_val", 32'(val1), 32'd9);
        chk_val("a_i2_idx", 32'(idx2), 32'd1);
        chk_val("a_i2_ovf4", 32'(ovf2), 32'd0);

        // Backpressure: junk beats offered while holding must be ignored
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_val("bp_valid", 32'(ov0), 32'd1);
            chk_val("bp_val", 32'({val0, idx0}), 32'h0901);
            chk_val("bp_ready", 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_val("bp_rel_valid", 32'(ov0), 32'd0);
        chk_val("bp_rel_ready", 32'(rdy0), 32'd1);
        chk_val("bp_keep_val", 32'(val0), 32'd9);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Frame B: 7F,80,01 max. signed -> 7F@0, unsigned -> 80@1
        send_beat(8'h7F, 1'b0, 1'b0);
        send_beat(8'h80, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0);
        chk_val("b_s_val", 32'(val1), 32'h7F);
        chk_val("b_s_idx", 32'(idx1), 32'd0);
        chk_val("b_u_val", 32'(val0), 32'h80);
        chk_val("b_u_idx", 32'(idx0), 32'd1);

        // Frame C: same data, min, mode toggled mid-frame (ignored).
        // signed -> 80@1, unsigned -> 01@2
        send_beat(8'h7F, 1'b0, 1'b1);
        send_beat(8'h80, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0);
        chk_val("c_s_val", 32'(val1), 32'h80);
        chk_val("c_s_idx", 32'(idx1), 32'd1);
        chk_val("c_u_val", 32'(val0), 32'h01);
        chk_val("c_u_idx", 32'(idx0), 32'd2);

        // Single-beat frames back to back with one idle in_ready=0 cycle
        send_beat(8'h42, 1'b1, 1'b0);
        chk_val("d_val", 32'({val0, idx0}), 32'h4200);
        chk_val("d_idle_rdy", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        chk_val("d_rdy_back", 32'(rdy0), 32'd1);
        chk_val("d_valid_drop", 32'(ov0), 32'd0);
        send_beat(8'h10, 1'b1, 1'b1);
        chk_val("e_val", 32'({val0, idx0}), 32'h1000);
        chk_val("e_ovf", 32'(ovf0), 32'd0);

        // Frame F: 1,1,1,1,1,7 -> IDX_W=2 saturates (idx 3, ovf 1)
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd7, 1'b1, 1'b0);
        chk_val("f_i2_val", 32'(val2), 32'd7);
        chk_val("f_i2_idx", 32'(idx2), 32'd3);
        chk_val("f_i2_ovf", 32'(ovf2), 32'd1);
        chk_val("f_u_idx", 32'(idx0), 32'd5);
        chk_val("f_u_ovf", 32'(ovf0), 32'd0);

        // Reset mid-frame after 5, 8; then 4, 2(last) -> 4 @ 0
        send_beat(8'd5, 1'b0, 1'b0);
        send_beat(8'd8, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outs("midrst");
        rst = 1'b0;
        send_beat(8'd4, 1'b0, 1'b0);
        send_beat(8'd2, 1'b1, 1'b0);
        chk_val("g_val", 32'({val0, idx0}), 32'h0400);
        chk_val("g_i2_val", 32'({val2, idx2}), 32'({8'd4, 2'd0}));
        chk_val("g_i2_ovf", 32'(ovf2), 32'd0);
        chk_val("g_valid", 32'({ov0, ov1, ov2}), 32'b111);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
